rs_frame_sequencer: RTL and testbench
=====================================

// Module: rs_frame_sequencer
// PURPOSE
//   Single-clock frame sequencer for the (N,K) decoder datapath.
//   - Collects N received bits into a codeword.
//   - Presents the codeword to the external syndrome/error-locator logic and applies the returned mask.
//   - Streams the K corrected data bits out through a valid/ready handshake and keeps error statistics.
//   - Replaces the multi-clock serial_to_parallel/parallel_to_serial glue with one clk_sys-domain controller.
// PARAMETERS
//   N        7   codeword length in bits
//   K        3   data bits emitted per frame (cw bits [K-1:0])
//   CNT_W    8   width of the saturating error counters
//   DROP_BAD 0   1: uncorrectable frames are not emitted; 0: emitted uncorrected
// PORTS
//   clk_sys      in   1      system clock; all logic on posedge
//   rst          in   1      asynchronous, active-high reset
//   bit_valid    in   1      bit_in is valid this cycle
//   bit_in       in   1      received serial bit, MSB of codeword first
//   bit_ready    out  1      sequencer accepts a bit (high only in COLLECT)
//   sync_clr     in   1      synchronous flush of a partial frame (realignment)
//   cw_out       out  N      registered codeword to the syndrome/locator logic
//   cw_strobe    out  1      high for the single CHECK cycle
//   err_mask     in   N      locator correction mask (combinational from cw_out)
//   err_detected in   1      locator flag: syndrome non-zero
//   dout         out  1      corrected data bit
//   dout_valid   out  1      dout is valid
//   dout_ready   in   1      sink accepts dout
//   dout_last    out  1      marks the K-th bit of a frame (qualified by dout_valid)
//   frame_err    out  1      1-cycle pulse: uncorrectable frame
//   corr_cnt     out  CNT_W  frames corrected (saturating)
//   uncorr_cnt   out  CNT_W  frames uncorrectable (saturating)
//   clear_cnt    in   1      synchronous clear of both counters
//   busy         out  1      state != COLLECT, or bit count != 0
// BEHAVIOUR
//   Reset values
//   - All outputs 0 except bit_ready = 1.
//   - State = COLLECT; bit count, cw_out and counters = 0.
//   - A reset mid-frame discards all partial data.
//   COLLECT
//   - A bit is accepted on bit_valid && bit_ready; the codeword register shifts left: cw <= {cw[N-2:0], bit_in}.
//   - The first bit accepted ends in cw[N-1].
//   - When the N-th bit is accepted: state -> CHECK, count -> 0.
//   - sync_clr in COLLECT: count -> 0 and any bit offered that cycle is dropped.
//   - sync_clr in any other state has no effect.
//   CHECK (exactly 1 cycle)
//   - cw_strobe = 1, bit_ready = 0.
//   - err_mask and err_detected are sampled at the end of the cycle.
//   - Classification:
//     - err_detected = 0: clean.
//     - err_detected = 1, mask != 0: corrected; fixed word = cw_out ^ err_mask.
//     - err_detected = 1, mask == 0: uncorrectable; fixed word = cw_out.
//   - Next state: EMIT, except uncorrectable with DROP_BAD = 1 -> COLLECT.
//   - frame_err pulses in the cycle after CHECK.
//   - The counter increment takes effect in the same cycle as the frame_err pulse.
//   EMIT
//   - dout = fixed[idx], dout_valid = 1, idx = 0..K-1 (LSB first).
//   - idx advances only on dout_valid && dout_ready.
//   - dout_last = 1 when idx == K-1.
//   - Handshake on idx == K-1: state -> COLLECT, idx -> 0.
//   - dout and dout_last hold stable while dout_ready = 0.
//   - bit_ready = 0 throughout EMIT; no overlap of collection and emission.
//   Latency
//   - N-th bit accepted in cycle t -> CHECK in t+1 -> first dout_valid in t+2.
//   - After the last handshake in cycle u, bit_ready = 1 in u+1.
//   Counters
//   - Saturate at all-ones; they do not wrap.
//   - clear_cnt takes priority over a same-cycle increment (result 0).
// TESTING
//   1. Clean frame: bits 0,0,1,0,0,1,1 with err_detected=0 -> cw_out=7'b0010011 with cw_strobe;
//      dout 1,1,0 with dout_last on the 3rd bit; counters stay 0.
//   2. Single error: bits 0010001, model returns mask 7'b0000010 with err_detected=1 ->
//      dout 1,1,0; corr_cnt=1; frame_err stays 0.
//   3. Uncorrectable, DROP_BAD=1: err_detected=1, mask=0 -> frame_err 1-cycle pulse at t+2;
//      no dout_valid; uncorr_cnt=1; bit_ready=1 at t+2.
//   4. Backpressure: dout_ready=0 for 5 cycles at idx=1 -> dout and dout_valid held stable,
//      bit_ready=0, bit_valid bits ignored; resumes on dout_ready=1.
//   5. Partial flush:
//      a. sync_clr after 4 bits -> next 7 bits form the frame (cw_out matches those 7 only).
//      b. rst asserted mid-EMIT -> all outputs at reset values immediately.
//   6. Saturation, CNT_W=2: 5 corrected frames -> corr_cnt=3; then clear_cnt coincident with an increment -> corr_cnt=0.

Source files
------------

// File: rtl/rs_frame_sequencer_if.sv
// Handshake/bus bundle for the frame sequencer. The slave modport is the
// sequencer's view; the master modport is the bit source, the locator and the sink.
interface rs_frame_sequencer_if #(
  parameter int N     = 7,
  parameter int CNT_W = 8
);
  logic             bit_valid;
  logic             bit_in;
  logic             bit_ready;
  logic             sync_clr;
  logic [N-1:0]     cw_out;
  logic             cw_strobe;
  logic [N-1:0]     err_mask;
  logic             err_detected;
  logic             dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic             frame_err;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;
  logic             clear_cnt;
  logic             busy;

  modport slave (
    input  bit_valid, bit_in, sync_clr, err_mask, err_detected, dout_ready, clear_cnt,
    output bit_ready, cw_out, cw_strobe, dout, dout_valid, dout_last, frame_err,
           corr_cnt, uncorr_cnt, busy
  );

  modport master (
    output bit_valid, bit_in, sync_clr, err_mask, err_detected, dout_ready, clear_cnt,
    input  bit_ready, cw_out, cw_strobe, dout, dout_valid, dout_last, frame_err,
           corr_cnt, uncorr_cnt, busy
  );
endinterface

// File: rtl/rs_frame_sequencer.sv
// Single-clock (N,K) frame sequencer: collects N serial bits, hands the codeword
// to the external syndrome/locator for one CHECK cycle, applies the returned
// mask and streams the K data bits out LSB first. Keeps saturating statistics.
module rs_frame_sequencer #(
  parameter int N        = 7,
  parameter int K        = 3,
  parameter int CNT_W    = 8,
  parameter int DROP_BAD = 0
) (
  input  logic clk_sys,
  input  logic rst,
  rs_frame_sequencer_if.slave bus
);

  localparam int CW = $clog2(N + 1);
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {COLLECT, CHECK, EMIT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [N-1:0]     cw;
  logic [K-1:0]     fixed;
  logic [IW-1:0]    idx;
  logic             bit_ready_q;
  logic             cw_strobe_q;
  logic             dout_q;
  logic             dout_valid_q;
  logic             dout_last_q;
  logic             frame_err_q;
  logic [CNT_W-1:0] corr_q;
  logic [CNT_W-1:0] uncorr_q;

  logic             accept;
  logic             hs;
  logic             mask_nz;
  logic             is_corr;
  logic             is_uncorr;
  logic [K-1:0]     fixed_lo;
  logic [IW-1:0]    idx_nxt;

  // Only the data bits of the corrected word are kept; parity bits are never emitted.
  always_comb begin
    accept    = bus.bit_valid && bit_ready_q;
    hs        = dout_valid_q && bus.dout_ready;
    mask_nz   = |bus.err_mask;
    is_corr   = bus.err_detected && mask_nz;
    is_uncorr = bus.err_detected && !mask_nz;
    fixed_lo  = cw[K-1:0] ^ (is_corr ? bus.err_mask[K-1:0] : '0);
    idx_nxt   = idx + 1'b1;
  end

  // Sequencer FSM; every handshake-facing output is a register updated here.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state        <= COLLECT;
      cnt          <= '0;
      cw           <= '0;
      fixed        <= '0;
      idx          <= '0;
      bit_ready_q  <= 1'b1;
      cw_strobe_q  <= 1'b0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cw_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        COLLECT: begin
          // Realignment flush wins over a bit offered in the same cycle.
          if (bus.sync_clr) begin
            cnt <= '0;
          end else if (accept) begin
            cw <= {cw[N-2:0], bus.bit_in};
            if (cnt == CW'(N - 1)) begin
              cnt         <= '0;
              state       <= CHECK;
              bit_ready_q <= 1'b0;
              cw_strobe_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          fixed       <= fixed_lo;
          frame_err_q <= is_uncorr;
          idx         <= '0;
          if (is_uncorr && (DROP_BAD != 0)) begin
            state       <= COLLECT;
            bit_ready_q <= 1'b1;
          end else begin
            state        <= EMIT;
            dout_valid_q <= 1'b1;
            dout_q       <= fixed_lo[0];
            dout_last_q  <= (K == 1);
          end
        end
        EMIT: begin
          // dout/dout_last only move on a handshake, so they hold under backpressure.
          if (hs) begin
            if (idx == IW'(K - 1)) begin
              state        <= COLLECT;
              bit_ready_q  <= 1'b1;
              dout_valid_q <= 1'b0;
              dout_q       <= 1'b0;
              dout_last_q  <= 1'b0;
              idx          <= '0;
            end else begin
              idx         <= idx_nxt;
              dout_q      <= fixed[idx_nxt];
              dout_last_q <= (idx_nxt == IW'(K - 1));
            end
          end
        end
        default: begin
          state       <= COLLECT;
          bit_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Saturating frame statistics; a clear beats a same-cycle increment.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (bus.clear_cnt) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (state == CHECK) begin
      if (is_corr && (corr_q != '1))
        corr_q <= corr_q + 1'b1;
      if (is_uncorr && (uncorr_q != '1))
        uncorr_q <= uncorr_q + 1'b1;
    end
  end

  assign bus.bit_ready  = bit_ready_q;
  assign bus.cw_out     = cw;
  assign bus.cw_strobe  = cw_strobe_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.corr_cnt   = corr_q;
  assign bus.uncorr_cnt = uncorr_q;
  assign bus.busy       = (state != COLLECT) || (cnt != '0);

endmodule

// File: tb/tb_rs_frame_sequencer.sv
// Directed bench for rs_frame_sequencer. Two instances share one stimulus:
// u_a uses the defaults (DROP_BAD=0, 8-bit counters), u_b uses DROP_BAD=1
// with 2-bit counters so drop and saturation behaviour are visible.
module tb_rs_frame_sequencer;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       sync_clr = 1'b0;
  logic [6:0] err_mask = '0;
  logic       err_detected = 1'b0;
  logic       dout_ready = 1'b0;
  logic       clear_cnt = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  rs_frame_sequencer_if #(.N(7), .CNT_W(8)) ifa ();
  rs_frame_sequencer_if #(.N(7), .CNT_W(2)) ifb ();

  assign ifa.bit_valid = bit_valid;     assign ifb.bit_valid = bit_valid;
  assign ifa.bit_in = bit_in;           assign ifb.bit_in = bit_in;
  assign ifa.sync_clr = sync_clr;       assign ifb.sync_clr = sync_clr;
  assign ifa.err_mask = err_mask;       assign ifb.err_mask = err_mask;
  assign ifa.err_detected = err_detected; assign ifb.err_detected = err_detected;
  assign ifa.dout_ready = dout_ready;   assign ifb.dout_ready = dout_ready;
  assign ifa.clear_cnt = clear_cnt;     assign ifb.clear_cnt = clear_cnt;

  rs_frame_sequencer #(.N(7), .K(3), .CNT_W(8), .DROP_BAD(0)) u_a (
    .clk_sys(clk_sys), .rst(rst), .bus(ifa.slave));
  rs_frame_sequencer #(.N(7), .K(3), .CNT_W(2), .DROP_BAD(1)) u_b (
    .clk_sys(clk_sys), .rst(rst), .bus(ifb.slave));

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Offers one codeword MSB first on consecutive cycles; returns in the CHECK cycle.
  task automatic send_frame(input logic [6:0] w);
    for (int i = 6; i >= 0; i--) begin
      bit_valid = 1'b1;
      bit_in = w[i];
      tick();
    end
    bit_valid = 1'b0;
    bit_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({ifa.bit_ready, ifa.cw_strobe, ifa.dout, ifa.dout_valid, ifa.dout_last, ifa.frame_err, ifa.busy} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_a_flags got=%b exp=1000000", {ifa.bit_ready, ifa.cw_strobe, ifa.dout, ifa.dout_valid, ifa.dout_last, ifa.frame_err, ifa.busy});
    end
    checks++;
    if ({ifa.cw_out, ifa.corr_cnt, ifa.uncorr_cnt} !== 23'd0) begin
      failures++;
      $display("FAIL reset_a_regs got cw=%b corr=%0d uncorr=%0d exp all 0", ifa.cw_out, ifa.corr_cnt, ifa.uncorr_cnt);
    end
    checks++;
    if ({ifb.bit_ready, ifb.dout_valid, ifb.busy, ifb.corr_cnt, ifb.uncorr_cnt} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_b got=%b exp=1000000", {ifb.bit_ready, ifb.dout_valid, ifb.busy, ifb.corr_cnt, ifb.uncorr_cnt});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clean();
    logic [2:0] exp;
    exp = 3'b011;
    dout_ready = 1'b1;
    send_frame(7'b0010011);
    checks++;
    if (ifa.cw_out !== 7'b0010011) begin
      failures++;
      $display("FAIL clean_cw got=%b exp=0010011", ifa.cw_out);
    end
    checks++;
    if ({ifa.cw_strobe, ifa.bit_ready, ifa.busy} !== 3'b101) begin
      failures++;
      $display("FAIL clean_check_flags got=%b exp=101", {ifa.cw_strobe, ifa.bit_ready, ifa.busy});
    end
    err_detected = 1'b0;
    err_mask = '0;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ifa.dout_valid, ifa.dout, ifa.dout_last, ifa.cw_strobe} !== {1'b1, exp[k], (k == 2), 1'b0}) begin
        failures++;
        $display("FAIL clean_emit_a[%0d] got v/d/l/s=%b exp=%b", k, {ifa.dout_valid, ifa.dout, ifa.dout_last, ifa.cw_strobe}, {1'b1, exp[k], (k == 2), 1'b0});
      end
      checks++;
      if ({ifb.dout_valid, ifb.dout, ifb.dout_last} !== {1'b1, exp[k], (k == 2)}) begin
        failures++;
        $display("FAIL clean_emit_b[%0d] got=%b exp=%b", k, {ifb.dout_valid, ifb.dout, ifb.dout_last}, {1'b1, exp[k], (k == 2)});
      end
      tick();
    end
    checks++;
    if ({ifa.bit_ready, ifa.dout_valid, ifa.corr_cnt, ifa.uncorr_cnt, ifb.corr_cnt, ifb.uncorr_cnt} !== {2'b10, 20'd0}) begin
      failures++;
      $display("FAIL clean_after got rdy=%b vld=%b corr=%0d uncorr=%0d", ifa.bit_ready, ifa.dout_valid, ifa.corr_cnt, ifa.uncorr_cnt);
    end
  endtask

  task automatic test_single_err();
    logic [2:0] exp;
    exp = 3'b011;
    send_frame(7'b0010001);
    checks++;
    if (ifa.cw_out !== 7'b0010001) begin
      failures++;
      $display("FAIL single_cw got=%b exp=0010001", ifa.cw_out);
    end
    err_detected = 1'b1;
    err_mask = 7'b0000010;
    tick();
    err_detected = 1'b0;
    err_mask = '0;
    checks++;
    if ({ifa.corr_cnt, ifa.frame_err, ifb.corr_cnt, ifb.frame_err} !== {8'd1, 1'b0, 2'd1, 1'b0}) begin
      failures++;
      $display("FAIL single_stats got corr_a=%0d fe_a=%b corr_b=%0d fe_b=%b exp 1 0 1 0", ifa.corr_cnt, ifa.frame_err, ifb.corr_cnt, ifb.frame_err);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ifa.dout_valid, ifa.dout, ifa.dout_last} !== {1'b1, exp[k], (k == 2)}) begin
        failures++;
        $display("FAIL single_emit[%0d] got=%b exp=%b", k, {ifa.dout_valid, ifa.dout, ifa.dout_last}, {1'b1, exp[k], (k == 2)});
      end
      tick();
    end
  endtask

  task automatic test_uncorrectable();
    send_frame(7'b1010101);
    err_detected = 1'b1;
    err_mask = '0;
    tick();
    err_detected = 1'b0;
    checks++;
    if ({ifa.frame_err, ifa.dout_valid, ifa.dout, ifa.uncorr_cnt} !== {3'b111, 8'd1}) begin
      failures++;
      $display("FAIL uncorr_a got fe/v/d=%b uncorr=%0d exp 111 1", {ifa.frame_err, ifa.dout_valid, ifa.dout}, ifa.uncorr_cnt);
    end
    checks++;
    if ({ifb.frame_err, ifb.dout_valid, ifb.bit_ready, ifb.uncorr_cnt} !== {3'b101, 2'd1}) begin
      failures++;
      $display("FAIL uncorr_drop_b got fe/v/rdy=%b uncorr=%0d exp 101 1", {ifb.frame_err, ifb.dout_valid, ifb.bit_ready}, ifb.uncorr_cnt);
    end
    tick();
    checks++;
    if ({ifa.frame_err, ifb.frame_err, ifb.dout_valid, ifa.dout_valid, ifa.dout} !== 5'b00010) begin
      failures++;
      $display("FAIL uncorr_pulse got=%b exp=00010", {ifa.frame_err, ifb.frame_err, ifb.dout_valid, ifa.dout_valid, ifa.dout});
    end
    tick();
    checks++;
    if ({ifa.dout_valid, ifa.dout, ifa.dout_last} !== 3'b111) begin
      failures++;
      $display("FAIL uncorr_last got=%b exp=111", {ifa.dout_valid, ifa.dout, ifa.dout_last});
    end
    tick();
    checks++;
    if (ifa.bit_ready !== 1'b1) begin
      failures++;
      $display("FAIL uncorr_ready got=%b exp=1", ifa.bit_ready);
    end
  endtask

  task automatic test_backpressure();
    send_frame(7'b0010011);
    tick();
    tick();
    dout_ready = 1'b0;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({ifa.dout_valid, ifa.dout, ifa.dout_last, ifa.bit_ready, ifb.dout_valid, ifb.dout} !== 6'b110011) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=%b exp=110011", c, {ifa.dout_valid, ifa.dout, ifa.dout_last, ifa.bit_ready, ifb.dout_valid, ifb.dout});
      end
      tick();
    end
    checks++;
    if (ifa.cw_out !== 7'b0010011) begin
      failures++;
      $display("FAIL bp_cw got=%b exp=0010011", ifa.cw_out);
    end
    bit_valid = 1'b0;
    bit_in = 1'b0;
    dout_ready = 1'b1;
    tick();
    checks++;
    if ({ifa.dout_valid, ifa.dout, ifa.dout_last} !== 3'b101) begin
      failures++;
      $display("FAIL bp_resume got=%b exp=101", {ifa.dout_valid, ifa.dout, ifa.dout_last});
    end
    tick();
    checks++;
    if ({ifa.bit_ready, ifa.dout_valid} !== 2'b10) begin
      failures++;
      $display("FAIL bp_done got=%b exp=10", {ifa.bit_ready, ifa.dout_valid});
    end
  endtask

  task automatic test_flush();
    logic [2:0] exp;
    exp = 3'b110;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_in = 1'b1;
      tick();
    end
    checks++;
    if ({ifa.busy, ifa.bit_ready} !== 2'b11) begin
      failures++;
      $display("FAIL flush_partial got busy/rdy=%b exp=11", {ifa.busy, ifa.bit_ready});
    end
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    bit_valid = 1'b0;
    checks++;
    if (ifa.busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy got=%b exp=0", ifa.busy);
    end
    send_frame(7'b0100110);
    checks++;
    if ({ifa.cw_strobe, ifa.cw_out, ifb.cw_out} !== {1'b1, 7'b0100110, 7'b0100110}) begin
      failures++;
      $display("FAIL flush_cw got strobe=%b cw_a=%b cw_b=%b exp 1 0100110", ifa.cw_strobe, ifa.cw_out, ifb.cw_out);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ifa.dout_valid, ifa.dout, ifa.dout_last} !== {1'b1, exp[k], (k == 2)}) begin
        failures++;
        $display("FAIL flush_emit[%0d] got=%b exp=%b", k, {ifa.dout_valid, ifa.dout, ifa.dout_last}, {1'b1, exp[k], (k == 2)});
      end
      tick();
    end
    // Reset in the middle of EMIT must clear everything without a clock edge.
    dout_ready = 1'b0;
    send_frame(7'b0010011);
    tick();
    checks++;
    if (ifa.dout_valid !== 1'b1) begin
      failures++;
      $display("FAIL midemit_pre got vld=%b exp=1", ifa.dout_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ifa.bit_ready, ifa.cw_strobe, ifa.dout, ifa.dout_valid, ifa.dout_last, ifa.frame_err, ifa.busy} !== 7'b1000000) begin
      failures++;
      $display("FAIL midemit_rst_flags got=%b exp=1000000", {ifa.bit_ready, ifa.cw_strobe, ifa.dout, ifa.dout_valid, ifa.dout_last, ifa.frame_err, ifa.busy});
    end
    checks++;
    if ({ifa.cw_out, ifa.corr_cnt, ifa.uncorr_cnt, ifb.corr_cnt, ifb.dout_valid} !== 26'd0) begin
      failures++;
      $display("FAIL midemit_rst_regs got cw=%b corr=%0d uncorr=%0d corr_b=%0d vld_b=%b exp 0", ifa.cw_out, ifa.corr_cnt, ifa.uncorr_cnt, ifb.corr_cnt, ifb.dout_valid);
    end
    rst = 1'b0;
    dout_ready = 1'b1;
    tick();
  endtask

  // Five corrected frames back to back, then a clear coinciding with a sixth.
  task automatic test_saturation();
    int expa;
    int expb;
    dout_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      send_frame(7'b0010001);
      err_detected = 1'b1;
      err_mask = 7'b0000010;
      clear_cnt = (f == 5);
      tick();
      err_detected = 1'b0;
      err_mask = '0;
      clear_cnt = 1'b0;
      expa = (f == 5) ? 0 : f + 1;
      expb = (f == 5) ? 0 : ((f + 1 > 3) ? 3 : f + 1);
      checks++;
      if (ifa.corr_cnt !== 8'(expa)) begin
        failures++;
        $display("FAIL sat_a[%0d] got=%0d exp=%0d", f, ifa.corr_cnt, expa);
      end
      checks++;
      if (ifb.corr_cnt !== 2'(expb)) begin
        failures++;
        $display("FAIL sat_b[%0d] got=%0d exp=%0d", f, ifb.corr_cnt, expb);
      end
      tick();
      tick();
      tick();
      checks++;
      if ({ifa.bit_ready, ifb.bit_ready, ifa.dout_valid} !== 3'b110) begin
        failures++;
        $display("FAIL b2b_ready[%0d] got=%b exp=110", f, {ifa.bit_ready, ifb.bit_ready, ifa.dout_valid});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_err();
    test_uncorrectable();
    test_backpressure();
    test_flush();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
